// File: rtl/handshake_pkg.sv
// handshake_pkg: shared types and helpers for the handshake width converters.
package handshake_pkg;

    localparam int unsigned MAX_RATIO = 16;
    localparam int unsigned LANE_W    = 4;

    typedef logic [LANE_W-1:0]    lane_t;
    typedef logic [MAX_RATIO-1:0] keep_t;

    function automatic int unsigned cnt_width(input int unsigned ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

    function automatic keep_t lane_mask(input lane_t k);
        return keep_t'((32'd2 << k) - 32'd1);
    endfunction

endpackage

// File: rtl/packer_out_reg.sv
// packer_out_reg: registered valid/ready output holding one packed word.
module packer_out_reg
    import handshake_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         can_load,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    assign can_load = ~out_valid | out_ready;

    // load is only raised when can_load, so a stalled word is never replaced
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/handshake_packer.sv
// handshake_packer: packs RATIO narrow beats into one wide valid/ready word.
// Define PACKER_FLUSH_EN to add in_last/out_last/out_keep partial-word flush.
module handshake_packer
    import handshake_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
`ifdef PACKER_FLUSH_EN
    input  logic                   in_last,
    output logic                   out_last,
    output logic [RATIO-1:0]       out_keep,
`endif
    output logic                   out_valid,
    output logic [WIDTH*RATIO-1:0] out_data,
    input  logic                   out_ready
);

    localparam int unsigned CW = cnt_width(RATIO);
    localparam int unsigned DW = WIDTH * RATIO;
`ifdef PACKER_FLUSH_EN
    localparam int unsigned PW = DW + RATIO + 1;
`else
    localparam int unsigned PW = DW;
`endif

    logic [CW-1:0] cnt;
    logic [DW-1:0] acc;
    logic [DW-1:0] word;
    logic [PW-1:0] payload;
    logic [PW-1:0] payload_q;
    logic          complete;
    logic          can_load;
    logic          accept;
    logic          load;

`ifdef PACKER_FLUSH_EN
    logic [RATIO-1:0] keep;

    assign complete = (cnt == CW'(RATIO - 1)) | in_last;
    assign keep     = RATIO'(lane_mask(lane_t'(cnt)));
    assign payload  = {in_last, keep, word};
    assign {out_last, out_keep, out_data} = payload_q;
`else
    assign complete = (cnt == CW'(RATIO - 1));
    assign payload  = word;
    assign out_data = payload_q;
`endif

    assign in_ready = ~complete | can_load;
    assign accept   = in_valid & in_ready;
    assign load     = accept & complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            cnt <= complete ? '0 : cnt + CW'(1);
            for (int i = 0; i < RATIO - 1; i++) begin
                if (!complete && cnt == CW'(i))
                    acc[i*WIDTH +: WIDTH] <= in_data;
            end
        end
    end

    // lanes below cnt come from acc, lane cnt is the live beat, the rest zero
    always_comb begin
        word = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) < cnt)
                word[i*WIDTH +: WIDTH] = acc[i*WIDTH +: WIDTH];
            else if (CW'(i) == cnt)
                word[i*WIDTH +: WIDTH] = in_data;
        end
    end

    packer_out_reg #(
        .W (PW)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (payload),
        .can_load  (can_load),
        .out_valid (out_valid),
        .out_data  (payload_q),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_handshake_packer.sv
// tb_handshake_packer: directed and scoreboarded checks for handshake_packer.
module tb_handshake_packer;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
`ifdef PACKER_FLUSH_EN
    logic        in_last;
    logic        out_last;
    logic [3:0]  out_keep;
`endif

    int vectors = 0;
    int errs    = 0;
    int words;
    int nbeats;
    int widx;
    int mcnt;
    bit mvalid;

    always #5 clk = ~clk;

    handshake_packer #(
        .WIDTH (WIDTH),
        .RATIO (RATIO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef PACKER_FLUSH_EN
        .in_last   (in_last),
        .out_last  (out_last),
        .out_keep  (out_keep),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
    endtask

    function automatic logic [31:0] seq_word(input int base, input int n);
        return {8'(base + 4*n + 3), 8'(base + 4*n + 2),
                8'(base + 4*n + 1), 8'(base + 4*n)};
    endfunction

    // one randomised cycle against an independent occupancy model
    task automatic rnd_cycle(input bit v, input bit r);
        bit exp_rdy;
        bit acc;
        bit xfer;
        in_valid  = v;
        out_ready = r;
        in_data   = v ? 8'(nbeats) : 8'($urandom);
        #2;
        exp_rdy = (mcnt != 3) || !mvalid || r;
        chk("rnd_in_ready", in_ready, exp_rdy);
        chk("rnd_out_valid", out_valid, mvalid);
        if (mvalid)
            chk("rnd_data", out_data, seq_word(0, widx));
        acc  = v && exp_rdy;
        xfer = mvalid && r;
        if (xfer)
            widx++;
        if (acc && mcnt == 3)
            mvalid = 1'b1;
        else if (xfer)
            mvalid = 1'b0;
        if (acc) begin
            nbeats++;
            mcnt = (mcnt + 1) % 4;
        end
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit exp_v;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
        in_last   = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);

        // four beats back to back
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 * (i + 1));
            #2;
            chk("t1_in_ready", in_ready, 1);
            chk("t1_no_early", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 32'h44332211);
        tick();
        chk("t1_one_cycle", out_valid, 0);

        // sixteen-beat stream, no gaps
        words = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h50 + i);
            #2;
            chk("t2_in_ready", in_ready, 1);
            exp_v = (i >= 1) && ((i - 1) % 4 == 3);
            chk("t2_valid", out_valid, exp_v);
            if (exp_v) begin
                chk("t2_word", out_data, seq_word(8'h50, (i - 1) / 4));
                words++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("t2_last_valid", out_valid, 1);
        chk("t2_last_word", out_data, seq_word(8'h50, 3));
        words++;
        chk("t2_words", words, 4);
        tick();
        chk("t2_drained", out_valid, 0);

        // back-pressure with a word pending
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            put(8'(8'hB0 + i));
        chk("t3_pend_valid", out_valid, 1);
        chk("t3_pend_data", out_data, 32'hB3B2B1B0);
        for (int k = 0; k < 3; k++) begin
            in_data = 8'(8'hC0 + k);
            #2;
            chk("t3_rdy_open", in_ready, 1);
            tick();
        end
        in_data = 8'hC3;
        #2;
        chk("t3_rdy_block", in_ready, 0);
        tick();
        #2;
        chk("t3_rdy_held", in_ready, 0);
        chk("t3_hold_valid", out_valid, 1);
        chk("t3_hold_data", out_data, 32'hB3B2B1B0);
        tick();
        out_ready = 1'b1;
        #2;
        chk("t3_rdy_comb", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t3_swap_valid", out_valid, 1);
        chk("t3_swap_data", out_data, 32'hC3C2C1C0);
        out_ready = 1'b1;
        tick();
        chk("t3_swap_done", out_valid, 0);

        // reset with a pending word and a half-filled one
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            put(8'(8'hE0 + i));
        put(8'hD1);
        put(8'hD2);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_valid", out_valid, 0);
        chk("t4_rst_data", out_data, 0);
        chk("t4_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            put(8'(8'hA1 + i));
        in_valid = 1'b0;
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, 32'hA4A3A2A1);
        tick();
        chk("t4_done", out_valid, 0);

`ifdef PACKER_FLUSH_EN
        put(8'h01);
        in_last = 1'b1;
        put(8'h02);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("fl_valid", out_valid, 1);
        chk("fl_data", out_data, 32'h00000201);
        chk("fl_keep", out_keep, 4'b0011);
        chk("fl_last", out_last, 1);
        tick();
        for (int i = 0; i < 4; i++)
            put(8'(8'h05 + i));
        in_valid = 1'b0;
        chk("fl_full_data", out_data, 32'h08070605);
        chk("fl_full_keep", out_keep, 4'b1111);
        chk("fl_full_last", out_last, 0);
        tick();
`endif

        // random valid/ready against the model and an in-order scoreboard
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        mvalid = 1'b0;
        mcnt   = 0;
        nbeats = 0;
        widx   = 0;
        cyc    = 0;
        while (nbeats < 1000 && cyc < 10000) begin
            rnd_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            cyc++;
        end
        repeat (2) rnd_cycle(1'b0, 1'b1);
        chk("rnd_beats", nbeats, 1000);
        chk("rnd_words", widx, 250);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/handshake_packer.md
# handshake_packer

Valid/ready width up-converter that sits directly downstream of a forward-registered handshake stage and consumes its narrow beat stream. It packs RATIO consecutive WIDTH-bit beats into one WIDTH*RATIO-bit word and presents that word on a registered valid/ready output. Both sides run at full throughput of one beat per cycle, and back-pressure propagates without loss.

## Interface
- WIDTH, 8, width of one input beat in bits.
- RATIO, 4, number of input beats per output word; legal range is 2 to 16.
- clk  input  1  rising-edge clock shared by both sides.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_data  input  WIDTH  upstream beat payload.
- in_ready  output  1  block accepts the beat this cycle; combinational.
- out_valid  output  reg 1  packed word valid.
- out_data  output  reg WIDTH*RATIO  packed word; beat 0 in bits [WIDTH-1:0].
- out_ready  input  1  downstream accepts the word.
- in_last, out_last, out_keep[RATIO]: present only under PACKER_FLUSH_EN (see Configuration).

## Operation
- An input beat is accepted when in_valid && in_ready. An output word is transferred when out_valid && out_ready.
- Lane counter cnt, width clog2(RATIO), resets to 0. Each accepted beat writes lane cnt, then cnt increments and wraps from RATIO-1 to 0.
- Lanes 0..RATIO-2 are written into an accumulation register. The beat for lane RATIO-1, together with the accumulation register, loads the output register in one edge.
- in_ready rules:
  - When cnt < RATIO-1, in_ready = 1 unconditionally.
  - When cnt == RATIO-1, in_ready = ~out_valid | out_ready.
- out_valid:
  - Sets on the edge that accepts the final lane.
  - Clears on an output transfer with no simultaneous final-lane accept.
  - Stays 1 when a transfer and a final-lane accept coincide; out_data takes the new word.
- out_data is held bit-stable while out_valid && !out_ready.
- in_data is ignored when in_valid = 0. Beats are never dropped or duplicated.
- Reset values: out_valid = 0, out_data = 0, cnt = 0, accumulation register = 0. in_ready = 1 in the first cycle after reset.
- rst mid-word discards every partially accumulated lane and any pending output word. There is no flush on reset.

## Timing
- Latency: a word is visible on out_valid one cycle after the edge that accepts its final beat.
- Throughput: one beat per cycle sustained, i.e. one word every RATIO cycles, when out_ready = 1.
- When out_ready is held at 0 with a word pending:
  - RATIO-1 further beats are accepted.
  - in_ready then drops and stays low until the cycle in which out_ready = 1.
- There is no combinational path from in_valid to out_valid. The only combinational path from out_ready is out_ready -> in_ready.

## Configuration
- PACKER_FLUSH_EN defined adds the following:
  - Ports in_last (1), out_last (1) and out_keep (RATIO).
  - An accepted beat with in_last = 1 at lane k completes the word immediately, using the same in_ready rule as the final lane.
  - The completed word has out_keep = lanes 0..k set, unused lanes of out_data zeroed, and out_last = 1. cnt returns to 0.
  - Full words without in_last have out_keep all ones and out_last = 0.
  - out_keep and out_last reset to 0.
- PACKER_FLUSH_EN undefined: these ports and their logic are absent, and only full words are ever emitted.

## Structure
- The shared package handshake_pkg holds:
  - The clog2-based counter-width constant function.
  - The lane-index typedef.
  - The keep-mask generation function, mask = (2 << k) - 1.
- The output holding register with its valid/ready logic is one natural sub-module, packer_out_reg. The counter and accumulation logic live in the top level.

## Test plan
- RATIO=4, WIDTH=8, out_ready=1, beats 0x11,0x22,0x33,0x44 back to back -> out_data=0x44332211 with out_valid high for exactly 1 cycle, one cycle after the 4th accept.
- Continuous stream of 16 beats with out_ready=1 -> 4 words, in_ready never low, no gaps.
- out_ready=0 with a word pending -> exactly 3 more beats accepted, then in_ready=0. Raise out_ready for 1 cycle -> old word transfers, new word loads in the same cycle, out_valid stays 1.
- Assert rst after 2 of 4 beats, then send 0xA1..0xA4 -> single word 0xA4A3A2A1, with no stale lanes.
- Random in_valid/out_ready toggling over 1000 beats against a scoreboard -> no loss, duplication or reordering, and out_data stable whenever stalled.
- PACKER_FLUSH_EN, beats 0x01,0x02 with in_last on the 2nd -> out_data=0x00000201, out_keep=4'b0011, out_last=1, cnt back to 0.
